// File: rtl/bp_me_pkg.sv
// Shared BedRock memory-side types: processor configs, message width and arbiter source IDs.
package bp_me_pkg;

    typedef enum logic {e_bp_default_cfg} bp_params_e;

    typedef enum logic {e_mem_src_0, e_mem_src_1} bp_mem_src_e;

    function automatic int cce_mem_msg_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 64;
            default:          return 64;
        endcase
    endfunction

endpackage

// File: rtl/bp_mem_order_fifo.sv
// 1r1w order FIFO; full/empty come from the registered count only (no bypass).
module bp_mem_order_fifo #(
    parameter  int width_p  = 1,
    parameter  int els_p    = 16,
    localparam int ptr_w_lp = $clog2(els_p)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ptr_w_lp:0]   count_q, count_d;
    logic                do_push, do_pop;

    assign full_o  = (count_q == (ptr_w_lp+1)'(els_p));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rptr_q];

    always_comb begin
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        wptr_d  = wptr_q + ptr_w_lp'(do_push);
        rptr_d  = rptr_q + ptr_w_lp'(do_pop);
        count_d = count_q + (ptr_w_lp+1)'(do_push) - (ptr_w_lp+1)'(do_pop);
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bp_mem_cmd_arbiter_2to1.sv
// Round-robin 2:1 merge of BedRock mem command streams; an order FIFO of source IDs steers responses.
module bp_mem_cmd_arbiter_2to1
    import bp_me_pkg::*;
#(
    parameter  bp_params_e bp_params_p          = e_bp_default_cfg,
    parameter  int         order_els_p          = 16,
    localparam int         cce_mem_msg_width_lp = cce_mem_msg_width(bp_params_p)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [1:0][cce_mem_msg_width_lp-1:0] cl_cmd_i,
    input  logic [1:0]                           cl_cmd_v_i,
    output logic [1:0]                           cl_cmd_ready_and_o,
    output logic [cce_mem_msg_width_lp-1:0]      cl_resp_o,
    output logic [1:0]                           cl_resp_v_o,
    input  logic [1:0]                           cl_resp_yumi_i,
    output logic [cce_mem_msg_width_lp-1:0]      mem_cmd_o,
    output logic                                 mem_cmd_v_o,
    input  logic                                 mem_cmd_ready_and_i,
    input  logic [cce_mem_msg_width_lp-1:0]      mem_resp_i,
    input  logic                                 mem_resp_v_i,
    output logic                                 mem_resp_yumi_o,
    output logic                                 err_o
);

    bp_mem_src_e rr_last_q, rr_last_d;
    bp_mem_src_e grant, head, non_head;
    logic        err_q, err_d;
    logic        full, empty, accept;
    logic [0:0]  head_id;

    bp_mem_order_fifo #(
        .width_p (1),
        .els_p   (order_els_p)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (accept),
        .data_i  (grant),
        .pop_i   (mem_resp_yumi_o),
        .data_o  (head_id),
        .full_o  (full),
        .empty_o (empty)
    );

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        case (cl_cmd_v_i)
            2'b01:   grant = e_mem_src_0;
            2'b10:   grant = e_mem_src_1;
            default: grant = bp_mem_src_e'(~rr_last_q);
        endcase

        head     = bp_mem_src_e'(head_id);
        non_head = bp_mem_src_e'(~head_id);

        // reset_i gates the handshakes so they drop the instant reset asserts
        mem_cmd_o          = cl_cmd_i[grant];
        mem_cmd_v_o        = reset_i & cl_cmd_v_i[grant] & ~full;
        cl_cmd_ready_and_o = '0;
        cl_cmd_ready_and_o[grant] = reset_i & mem_cmd_ready_and_i & ~full;
        accept             = mem_cmd_v_o & mem_cmd_ready_and_i;

        cl_resp_o         = mem_resp_i;
        cl_resp_v_o       = '0;
        cl_resp_v_o[head] = reset_i & mem_resp_v_i & ~empty;
        mem_resp_yumi_o   = cl_resp_yumi_i[head] & cl_resp_v_o[head];

        rr_last_d = accept ? grant : rr_last_q;
        err_d     = err_q
                  | (mem_resp_v_i & empty)
                  | (~empty & cl_resp_yumi_i[non_head]);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rr_last_q <= e_mem_src_1;
            err_q     <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
            err_q     <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_bp_mem_cmd_arbiter_2to1.sv
// Directed bench for the 2:1 mem command arbiter; inputs change on negedge, outputs checked 1ns later.
module tb_bp_mem_cmd_arbiter_2to1;
    import bp_me_pkg::*;

    localparam int MSG = cce_mem_msg_width(e_bp_default_cfg);

    logic                clk_i = 1'b0;
    logic                reset_i = 1'b0;
    logic [1:0][MSG-1:0] cl_cmd_i;
    logic [1:0]          cl_cmd_v_i;
    logic [1:0]          cl_cmd_ready_and_o;
    logic [MSG-1:0]      cl_resp_o;
    logic [1:0]          cl_resp_v_o;
    logic [1:0]          cl_resp_yumi_i;
    logic [MSG-1:0]      mem_cmd_o;
    logic                mem_cmd_v_o;
    logic                mem_cmd_ready_and_i;
    logic [MSG-1:0]      mem_resp_i;
    logic                mem_resp_v_i;
    logic                mem_resp_yumi_o;
    logic                err_o;

    int total = 0;
    int bad   = 0;

    bp_mem_cmd_arbiter_2to1 #(.bp_params_p(e_bp_default_cfg), .order_els_p(16)) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .cl_cmd_i            (cl_cmd_i),
        .cl_cmd_v_i          (cl_cmd_v_i),
        .cl_cmd_ready_and_o  (cl_cmd_ready_and_o),
        .cl_resp_o           (cl_resp_o),
        .cl_resp_v_o         (cl_resp_v_o),
        .cl_resp_yumi_i      (cl_resp_yumi_i),
        .mem_cmd_o           (mem_cmd_o),
        .mem_cmd_v_o         (mem_cmd_v_o),
        .mem_cmd_ready_and_i (mem_cmd_ready_and_i),
        .mem_resp_i          (mem_resp_i),
        .mem_resp_v_i        (mem_resp_v_i),
        .mem_resp_yumi_o     (mem_resp_yumi_o),
        .err_o               (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        cl_cmd_i            = '0;
        cl_cmd_v_i          = '0;
        cl_resp_yumi_i      = '0;
        mem_cmd_ready_and_i = 1'b0;
        mem_resp_i          = '0;
        mem_resp_v_i        = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle();
        reset_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset_i             = 1'b0;
        cl_cmd_v_i          = 2'b11;
        mem_cmd_ready_and_i = 1'b1;
        mem_resp_v_i        = 1'b1;
        cl_resp_yumi_i      = 2'b11;
        @(negedge clk_i);
        #1;
        total++;
        if ({mem_cmd_v_o, cl_cmd_ready_and_o, cl_resp_v_o, mem_resp_yumi_o, err_o} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b rdy=%b rv=%b yumi=%b err=%b, want all 0",
                     mem_cmd_v_o, cl_cmd_ready_and_o, cl_resp_v_o, mem_resp_yumi_o, err_o);
        end
        idle();
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    task automatic test_single_client();
        logic [MSG-1:0] addr [3];
        addr[0] = 64'h8000_0000;
        addr[1] = 64'h8000_0040;
        addr[2] = 64'h8000_0080;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            idle();
            cl_cmd_v_i          = 2'b01;
            cl_cmd_i[0]         = addr[i];
            mem_cmd_ready_and_i = 1'b1;
            #1;
            total++;
            if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== addr[i] || cl_cmd_ready_and_o !== 2'b01) begin
                bad++;
                $display("FAIL single_cmd%0d: got v=%b cmd=%h rdy=%b, want v=1 cmd=%h rdy=01",
                         i, mem_cmd_v_o, mem_cmd_o, cl_cmd_ready_and_o, addr[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            idle();
            mem_resp_v_i   = 1'b1;
            mem_resp_i     = 64'hD000 + 64'(i);
            cl_resp_yumi_i = 2'b01;
            #1;
            total++;
            if (cl_resp_v_o !== 2'b01 || cl_resp_o !== 64'hD000 + 64'(i) || mem_resp_yumi_o !== 1'b1) begin
                bad++;
                $display("FAIL single_resp%0d: got rv=%b data=%h yumi=%b, want rv=01 data=%h yumi=1",
                         i, cl_resp_v_o, cl_resp_o, mem_resp_yumi_o, 64'hD000 + 64'(i));
            end
        end
        @(negedge clk_i);
        idle();
        #1;
        total++;
        if (cl_resp_v_o !== 2'b00 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL single_drained: got rv=%b err=%b, want rv=00 err=0", cl_resp_v_o, err_o);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic [MSG-1:0] exp_cmd;
            logic [1:0]     exp_rdy;
            exp_cmd = (i % 2 == 1) ? 64'hB0 + 64'(i) : 64'hA0 + 64'(i);
            exp_rdy = (i % 2 == 1) ? 2'b10 : 2'b01;
            @(negedge clk_i);
            idle();
            cl_cmd_v_i          = 2'b11;
            cl_cmd_i[0]         = 64'hA0 + 64'(i);
            cl_cmd_i[1]         = 64'hB0 + 64'(i);
            mem_cmd_ready_and_i = 1'b1;
            #1;
            total++;
            if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== exp_cmd || cl_cmd_ready_and_o !== exp_rdy) begin
                bad++;
                $display("FAIL alt_grant%0d: got v=%b cmd=%h rdy=%b, want v=1 cmd=%h rdy=%b",
                         i, mem_cmd_v_o, mem_cmd_o, cl_cmd_ready_and_o, exp_cmd, exp_rdy);
            end
        end
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_rv;
            exp_rv = (i % 2 == 1) ? 2'b10 : 2'b01;
            @(negedge clk_i);
            idle();
            mem_resp_v_i   = 1'b1;
            mem_resp_i     = 64'hE0 + 64'(i);
            cl_resp_yumi_i = exp_rv;
            #1;
            total++;
            if (cl_resp_v_o !== exp_rv || cl_resp_o !== 64'hE0 + 64'(i) || mem_resp_yumi_o !== 1'b1) begin
                bad++;
                $display("FAIL alt_resp%0d: got rv=%b data=%h yumi=%b, want rv=%b data=%h yumi=1",
                         i, cl_resp_v_o, cl_resp_o, mem_resp_yumi_o, exp_rv, 64'hE0 + 64'(i));
            end
        end
        @(negedge clk_i);
        idle();
        #1;
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("FAIL alt_err: got err=%b, want 0", err_o);
        end
    endtask

    task automatic test_full_stall();
        int stall_bad;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            idle();
            cl_cmd_v_i          = 2'b01;
            cl_cmd_i[0]         = 64'h100 + 64'(i);
            mem_cmd_ready_and_i = 1'b1;
            #1;
            total++;
            if (mem_cmd_v_o !== 1'b1 || cl_cmd_ready_and_o !== 2'b01) begin
                bad++;
                $display("FAIL fill%0d: got v=%b rdy=%b, want v=1 rdy=01", i, mem_cmd_v_o, cl_cmd_ready_and_o);
            end
        end
        // 17th command waits out the remaining response latency
        stall_bad = 0;
        for (int i = 16; i < 100; i++) begin
            @(negedge clk_i);
            idle();
            cl_cmd_v_i          = 2'b01;
            cl_cmd_i[0]         = 64'h200;
            mem_cmd_ready_and_i = 1'b1;
            #1;
            if (mem_cmd_v_o !== 1'b0 || cl_cmd_ready_and_o !== 2'b00) stall_bad++;
        end
        total++;
        if (stall_bad !== 0) begin
            bad++;
            $display("FAIL full_stall: got %0d cycles with 17th cmd passing, want 0", stall_bad);
        end
        @(negedge clk_i);
        mem_resp_v_i   = 1'b1;
        mem_resp_i     = 64'hF00;
        cl_resp_yumi_i = 2'b01;
        #1;
        total++;
        if (mem_resp_yumi_o !== 1'b1 || cl_resp_v_o !== 2'b01 || mem_cmd_v_o !== 1'b0 || cl_cmd_ready_and_o !== 2'b00) begin
            bad++;
            $display("FAIL full_pop_cycle: got yumi=%b rv=%b v=%b rdy=%b, want yumi=1 rv=01 v=0 rdy=00",
                     mem_resp_yumi_o, cl_resp_v_o, mem_cmd_v_o, cl_cmd_ready_and_o);
        end
        @(negedge clk_i);
        mem_resp_v_i   = 1'b0;
        cl_resp_yumi_i = 2'b00;
        #1;
        total++;
        if (mem_cmd_v_o !== 1'b1 || cl_cmd_ready_and_o !== 2'b01 || mem_cmd_o !== 64'h200) begin
            bad++;
            $display("FAIL full_after_pop: got v=%b rdy=%b cmd=%h, want v=1 rdy=01 cmd=200",
                     mem_cmd_v_o, cl_cmd_ready_and_o, mem_cmd_o);
        end
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_err();
        do_reset();
        @(negedge clk_i);
        idle();
        mem_resp_v_i   = 1'b1;
        cl_resp_yumi_i = 2'b11;
        #1;
        total++;
        if (mem_resp_yumi_o !== 1'b0 || cl_resp_v_o !== 2'b00 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL err_empty_resp: got yumi=%b rv=%b err=%b, want yumi=0 rv=00 err=0",
                     mem_resp_yumi_o, cl_resp_v_o, err_o);
        end
        @(negedge clk_i);
        idle();
        #1;
        total++;
        if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL err_set: got err=%b, want 1", err_o);
        end
        repeat (5) @(negedge clk_i);
        #1;
        total++;
        if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got err=%b, want 1", err_o);
        end
        do_reset();
        @(negedge clk_i);
        idle();
        cl_cmd_v_i          = 2'b01;
        mem_cmd_ready_and_i = 1'b1;
        @(negedge clk_i);
        idle();
        mem_resp_v_i   = 1'b1;
        cl_resp_yumi_i = 2'b10;
        #1;
        total++;
        if (cl_resp_v_o !== 2'b01 || mem_resp_yumi_o !== 1'b0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL err_nonhead_yumi: got rv=%b yumi=%b err=%b, want rv=01 yumi=0 err=0",
                     cl_resp_v_o, mem_resp_yumi_o, err_o);
        end
        @(negedge clk_i);
        idle();
        #1;
        total++;
        if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL err_nonhead_set: got err=%b, want 1", err_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk_i);
        idle();
        mem_resp_v_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            idle();
            cl_cmd_v_i          = 2'b11;
            mem_cmd_ready_and_i = 1'b1;
        end
        @(negedge clk_i);
        idle();
        cl_cmd_v_i          = 2'b11;
        mem_cmd_ready_and_i = 1'b1;
        mem_resp_v_i        = 1'b1;
        cl_resp_yumi_i      = 2'b11;
        #2;
        reset_i = 1'b0;
        #1;
        total++;
        if ({mem_cmd_v_o, cl_cmd_ready_and_o, cl_resp_v_o, mem_resp_yumi_o, err_o} !== 7'b0) begin
            bad++;
            $display("FAIL mid_reset_async: got v=%b rdy=%b rv=%b yumi=%b err=%b, want all 0",
                     mem_cmd_v_o, cl_cmd_ready_and_o, cl_resp_v_o, mem_resp_yumi_o, err_o);
        end
        @(negedge clk_i);
        idle();
        reset_i = 1'b1;
        @(negedge clk_i);
        cl_cmd_v_i          = 2'b11;
        cl_cmd_i[0]         = 64'hC0;
        cl_cmd_i[1]         = 64'hC1;
        mem_cmd_ready_and_i = 1'b1;
        mem_resp_v_i        = 1'b1;
        #1;
        total++;
        if (cl_cmd_ready_and_o !== 2'b01 || mem_cmd_o !== 64'hC0 || cl_resp_v_o !== 2'b00
            || mem_resp_yumi_o !== 1'b0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_after: got rdy=%b cmd=%h rv=%b yumi=%b err=%b, want rdy=01 cmd=c0 rv=00 yumi=0 err=0",
                     cl_cmd_ready_and_o, mem_cmd_o, cl_resp_v_o, mem_resp_yumi_o, err_o);
        end
        @(negedge clk_i);
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_client();
        test_alternate();
        test_full_stall();
        test_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
